// File: rtl/pdp8_bus_pkg.sv
// Shared types and constants for the PDP-8 pin-bus responder.
// Holds data phase codes, the IO-select opcode, the fetch FSM state type,
// the decoded-bus payload struct and the nibble-select helper.
package pdp8_bus_pkg;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned IOSEL_W = 5;
    localparam int unsigned CNT_W   = 2;

    localparam logic [1:0] PH_HI  = 2'b00;
    localparam logic [1:0] PH_MID = 2'b01;
    localparam logic [1:0] PH_LO  = 2'b10;

    localparam logic [2:0] IO_SEL_CODE = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CYC_NONE  = 2'd0,
        CYC_ADDR  = 2'd1,
        CYC_IOSEL = 2'd2,
        CYC_DATA  = 2'd3
    } cyc_t;

    typedef struct packed {
        cyc_t       kind;
        logic       addr_hi;   // address latch targets addr[11:6]
        logic [1:0] phase;     // data phase selector
        logic       wr;        // data phase carries write data
        logic [5:0] payload;   // raw bus[5:0]
    } bus_dec_t;

    // Pick the 4-bit slice of a 12-bit word addressed by a data phase.
    function automatic logic [NIB_W-1:0] nibble_sel(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] ph);
        case (ph)
            PH_HI:   return w[11:8];
            PH_MID:  return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

endpackage

// File: rtl/pdp8_bus_decode.sv
// Combinational classifier for one byte of the CPU pin bus.
// Ports: bus (CPU output pins), dec_c (cycle kind, phase, write flag, payload).
// With PDP8_BUS_IO_EN undefined, IO-select bytes decode as CYC_NONE.
module pdp8_bus_decode
    import pdp8_bus_pkg::*;
(
    input  logic [7:0] bus,
    output bus_dec_t   dec_c
);

    always_comb begin
        dec_c.kind    = CYC_NONE;
        dec_c.addr_hi = bus[6];
        dec_c.phase   = bus[6:5];
        dec_c.wr      = bus[4];
        dec_c.payload = bus[5:0];
        if (bus[7]) begin
            dec_c.kind = CYC_ADDR;
        end else if (bus[7:5] != IO_SEL_CODE) begin
            dec_c.kind = CYC_DATA;
        end
`ifdef PDP8_BUS_IO_EN
        else begin
            dec_c.kind = CYC_IOSEL;
        end
`endif
    end

endmodule

// File: rtl/pdp8_bus_responder.sv
// Far-end responder for the PDP-8 8-bit multiplexed pin bus.
// Latches addresses, fetches 12-bit words from a synchronous SRAM (or IO
// device), returns them nibble by nibble on bus_in and assembles nibble
// writes into 12-bit write strobes.
// Ports: clk/rst (sync, active-high); bus_out in; bus_in out; SRAM port
// mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata; IO port io_mode/io_sel/
// io_rdata/io_wr/io_wdata; rd_valid.
// Optional feature macro: PDP8_BUS_IO_EN enables IO select and IO access.
module pdp8_bus_responder
    import pdp8_bus_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,   // 1..3
    parameter int unsigned ADDR_W  = 12   // must be 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        bus_out,
    output logic [3:0]        bus_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [11:0]       mem_rdata,
    output logic              mem_wr,
    output logic [11:0]       mem_wdata,
    output logic              io_mode,
    output logic [4:0]        io_sel,
    input  logic [11:0]       io_rdata,
    output logic              io_wr,
    output logic [11:0]       io_wdata,
    output logic              rd_valid
);

    bus_dec_t            dec_c;
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   rd_buf, rd_buf_nxt_c, fetch_data_c, commit_word_c;
    logic                rd_valid_nxt_c, fetch_done_c, commit_c;
    logic [1:0]          rd_sel, rd_sel_nxt_c;
    logic [7:0]          wtmp;
    logic                have_hi, have_mid;
    logic                is_addr, is_io, is_rd_ph, is_wr_ph;

    pdp8_bus_decode u_decode (
        .bus   (bus_out),
        .dec_c (dec_c)
    );

    assign is_addr       = (dec_c.kind == CYC_ADDR);
    assign is_io         = (dec_c.kind == CYC_IOSEL);
    assign is_rd_ph      = (dec_c.kind == CYC_DATA) && !dec_c.wr;
    assign is_wr_ph      = (dec_c.kind == CYC_DATA) && dec_c.wr;
    assign commit_word_c = {wtmp, dec_c.payload[3:0]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // FSM next state: a latch or IO select (re)starts a fetch
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (is_addr) begin
            state_nxt = ST_FETCH;
            cnt_nxt   = CNT_W'(MEM_LAT - 1);   // capture lands MEM_LAT edges after the latch
        end else if (is_io) begin
            state_nxt = ST_FETCH;
            cnt_nxt   = '0;                   // IO data is sampled on the very next edge
        end else if (state == ST_FETCH) begin
            if (cnt == '0) begin
                state_nxt = ST_VALID;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    // FSM outputs: read buffer update, commit beats fetch capture
    always_comb begin
        fetch_done_c   = (state == ST_FETCH) && (cnt == '0) && !is_addr && !is_io;
        commit_c       = is_wr_ph && (dec_c.phase == PH_LO) && have_mid;
        rd_buf_nxt_c   = rd_buf;
        rd_valid_nxt_c = rd_valid;
        rd_sel_nxt_c   = is_rd_ph ? dec_c.phase : rd_sel;
        if (is_addr || is_io) begin
            rd_valid_nxt_c = 1'b0;
        end else if (commit_c) begin
            rd_buf_nxt_c   = commit_word_c;
            rd_valid_nxt_c = 1'b1;
        end else if (fetch_done_c) begin
            rd_buf_nxt_c   = fetch_data_c;
            rd_valid_nxt_c = 1'b1;
        end
    end

    // Address, read path and memory write strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            rd_buf    <= '0;
            rd_valid  <= 1'b0;
            rd_sel    <= PH_HI;
            bus_in    <= '0;
            wtmp      <= '0;
            have_hi   <= 1'b0;
            have_mid  <= 1'b0;
        end else begin
            mem_rd   <= is_addr;
            mem_wr   <= commit_c && !io_mode;
            rd_buf   <= rd_buf_nxt_c;
            rd_valid <= rd_valid_nxt_c;
            rd_sel   <= rd_sel_nxt_c;
            // Tracks the selected nibble so write-through data shows up at once
            bus_in   <= nibble_sel(rd_buf_nxt_c, rd_sel_nxt_c);
            if (commit_c && !io_mode) begin
                mem_wdata <= commit_word_c;
            end
            if (is_addr) begin
                if (dec_c.addr_hi) begin
                    mem_addr[11:6] <= dec_c.payload;
                end else begin
                    mem_addr[5:0] <= dec_c.payload;
                end
            end
            // A commit needs a complete HI, MID, LO write sequence since reset
            if (is_wr_ph) begin
                case (dec_c.phase)
                    PH_HI: begin
                        wtmp[7:4] <= dec_c.payload[3:0];
                        have_hi   <= 1'b1;
                        have_mid  <= 1'b0;
                    end
                    PH_MID: begin
                        if (have_hi) begin
                            wtmp[3:0] <= dec_c.payload[3:0];
                            have_mid  <= 1'b1;
                        end
                    end
                    default: begin
                        have_hi  <= 1'b0;
                        have_mid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PDP8_BUS_IO_EN
    logic io_src;

    // IO select state and IO write strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            io_mode  <= 1'b0;
            io_sel   <= '0;
            io_wr    <= 1'b0;
            io_wdata <= '0;
            io_src   <= 1'b0;
        end else begin
            io_wr <= commit_c && io_mode;
            if (commit_c && io_mode) begin
                io_wdata <= commit_word_c;
            end
            if (is_addr) begin
                io_mode <= 1'b0;
                io_src  <= 1'b0;
            end else if (is_io) begin
                io_mode <= 1'b1;
                io_sel  <= IOSEL_W'(dec_c.payload[4:0]);
                io_src  <= 1'b1;
            end
        end
    end

    assign fetch_data_c = io_src ? io_rdata : mem_rdata;
`else
    logic unused_io_rdata;

    assign io_mode         = 1'b0;
    assign io_sel          = '0;
    assign io_wr           = 1'b0;
    assign io_wdata        = '0;
    assign fetch_data_c    = mem_rdata;
    assign unused_io_rdata = ^io_rdata;
`endif

endmodule

// File: tb/tb_pdp8_bus_responder.sv
// Self-checking bench for pdp8_bus_responder (MEM_LAT=3, combinational SRAM
// model behind mem_addr). Expected write strobes and read nibbles are queued
// as stimulus is driven and compared when the DUT produces them.
module tb_pdp8_bus_responder;

    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [11:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk, rst;
    logic [7:0]  bus_out;
    logic [3:0]  bus_in;
    logic [11:0] mem_addr, mem_rdata, mem_wdata, io_rdata, io_wdata;
    logic        mem_rd, mem_wr, io_mode, io_wr, rd_valid;
    logic [4:0]  io_sel;

    logic [11:0] mem [4096];
    assign mem_rdata = mem[mem_addr];

    wr_t         exp_mem[$], obs_mem[$];
    logic [11:0] exp_io[$], obs_io[$];
    logic [3:0]  exp_nib[$];
    int          rd_pulses = 0;
    int          checks = 0;
    int          errors = 0;

    pdp8_bus_responder #(.MEM_LAT(LAT), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .bus_out(bus_out), .bus_in(bus_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .io_mode(io_mode),
        .io_sel(io_sel), .io_rdata(io_rdata), .io_wr(io_wr),
        .io_wdata(io_wdata), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record strobes away from the active edge
    always @(negedge clk) begin
        if (mem_wr) obs_mem.push_back({mem_addr, mem_wdata});
        if (io_wr)  obs_io.push_back(io_wdata);
        if (mem_rd) rd_pulses++;
    end

    task automatic cyc(input logic [7:0] b);
        bus_out = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_nib(input logic [11:0] w, input int i);
        logic [11:0] s;
        s = w >> (8 - 4 * i);
        return s[3:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cyc(8'h00);
        cyc(8'h00);
        checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if ({mem_rd, mem_wr, io_wr, io_mode, rd_valid} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_rd, mem_wr, io_wr, io_mode, rd_valid}); end
        checks++; if (bus_in !== 4'h0) begin errors++; $display("FAIL reset_bus_in got=%h exp=0", bus_in); end
        checks++; if ({mem_wdata, io_wdata, io_sel} !== 29'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {mem_wdata, io_wdata, io_sel}); end
        rst = 1'b0;
    endtask

    task automatic test_latch();
        logic [7:0] ph [3];
        int pre;
        ph[0] = 8'h00; ph[1] = 8'h20; ph[2] = 8'h40;
        cyc(8'hC5);
        cyc(8'h8A);
        checks++; if (mem_addr !== 12'o0512) begin errors++; $display("FAIL latch_addr got=%o exp=0512", mem_addr); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL latch_mem_rd got=%b exp=1", mem_rd); end
        pre = rd_pulses;
        for (int k = 1; k <= int'(LAT); k++) begin
            cyc(8'h00);
            checks++;
            if (rd_valid !== (k == int'(LAT))) begin
                errors++; $display("FAIL latch_rd_valid_c%0d got=%b exp=%b", k, rd_valid, (k == int'(LAT)));
            end
        end
        checks++; if (rd_pulses - pre != 1 || mem_rd !== 1'b0) begin errors++; $display("FAIL latch_rd_pulses got=%0d exp=1", rd_pulses - pre); end
        for (int i = 0; i < 3; i++) begin
            logic [3:0] e;
            exp_nib.push_back(model_nib(12'o7342, i));
            cyc(ph[i]);
            e = exp_nib.pop_front();
            checks++; if (bus_in !== e) begin errors++; $display("FAIL latch_nib%0d got=%h exp=%h", i, bus_in, e); end
        end
    endtask

    task automatic test_write();
        wr_t got, e;
        cyc(8'hC1);
        cyc(8'h80);
        for (int k = 0; k < int'(LAT); k++) cyc(8'h00);
        exp_mem.push_back({12'h040, 12'h345});
        cyc(8'h13);
        cyc(8'h34);
        cyc(8'h55);
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL write_strobe got=%b exp=1", mem_wr); end
        cyc(8'h00);
        checks++; if (bus_in !== 4'h3 || rd_valid !== 1'b1) begin errors++; $display("FAIL write_through got=%h/%b exp=3/1", bus_in, rd_valid); end
        checks++;
        if (obs_mem.size() != 1) begin
            errors++; $display("FAIL write_count got=%0d exp=1", obs_mem.size());
            obs_mem.delete(); exp_mem.delete();
        end else begin
            got = obs_mem.pop_front(); e = exp_mem.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL write_word got=%h exp=%h", got, e); end
        end
    endtask

`ifdef PDP8_BUS_IO_EN
    task automatic test_io();
        logic [7:0] ph [3];
        logic [11:0] got, e;
        ph[0] = 8'h00; ph[1] = 8'h20; ph[2] = 8'h40;
        cyc(8'h67);
        checks++; if (io_mode !== 1'b1 || io_sel !== 5'd7) begin errors++; $display("FAIL io_select got=%b/%0d exp=1/7", io_mode, io_sel); end
        cyc(8'h00);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL io_rd_valid got=%b exp=1", rd_valid); end
        for (int i = 0; i < 3; i++) begin
            logic [3:0] en;
            exp_nib.push_back(model_nib(12'hABC, i));
            cyc(ph[i]);
            en = exp_nib.pop_front();
            checks++; if (bus_in !== en) begin errors++; $display("FAIL io_nib%0d got=%h exp=%h", i, bus_in, en); end
        end
        exp_io.push_back(12'h123);
        cyc(8'h11);
        cyc(8'h32);
        cyc(8'h53);
        cyc(8'h00);
        checks++;
        if (obs_io.size() != 1) begin
            errors++; $display("FAIL io_write_count got=%0d exp=1", obs_io.size());
            obs_io.delete(); exp_io.delete();
        end else begin
            got = obs_io.pop_front(); e = exp_io.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL io_wdata got=%h exp=%h", got, e); end
        end
        checks++; if (obs_mem.size() != 0) begin errors++; $display("FAIL io_no_mem_wr got=%0d exp=0", obs_mem.size()); obs_mem.delete(); end
        cyc(8'h80);
        checks++; if (io_mode !== 1'b0) begin errors++; $display("FAIL io_mode_clear got=%b exp=0", io_mode); end
    endtask
`else
    task automatic test_no_io();
        wr_t got, e;
        cyc(8'h67);
        checks++; if (io_mode !== 1'b0 || io_sel !== 5'd0) begin errors++; $display("FAIL noio_select got=%b/%0d exp=0/0", io_mode, io_sel); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL noio_ignored got=%b exp=1", rd_valid); end
        exp_mem.push_back({mem_addr, 12'h123});
        cyc(8'h11);
        cyc(8'h32);
        cyc(8'h53);
        cyc(8'h00);
        checks++; if (io_wr !== 1'b0 || obs_io.size() != 0) begin errors++; $display("FAIL noio_io_wr got=%0d exp=0", obs_io.size()); end
        checks++;
        if (obs_mem.size() != 1) begin
            errors++; $display("FAIL noio_write_count got=%0d exp=1", obs_mem.size());
            obs_mem.delete(); exp_mem.delete();
        end else begin
            got = obs_mem.pop_front(); e = exp_mem.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL noio_write_word got=%h exp=%h", got, e); end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] ph [3];
        ph[0] = 8'h00; ph[1] = 8'h20; ph[2] = 8'h40;
        cyc(8'hC0);
        cyc(8'h81);
        cyc(8'h82);
        checks++; if (mem_addr !== 12'h002 || rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_addr got=%h/%b exp=002/0", mem_addr, rd_valid); end
        for (int k = 1; k <= int'(LAT); k++) begin
            cyc(8'h00);
            checks++;
            if (rd_valid !== (k == int'(LAT))) begin
                errors++; $display("FAIL b2b_rd_valid_c%0d got=%b exp=%b", k, rd_valid, (k == int'(LAT)));
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [3:0] e;
            exp_nib.push_back(model_nib(12'h2A7, i));
            cyc(ph[i]);
            e = exp_nib.pop_front();
            checks++; if (bus_in !== e) begin errors++; $display("FAIL b2b_nib%0d got=%h exp=%h", i, bus_in, e); end
        end
    endtask

    task automatic test_reset_mid_write();
        cyc(8'h13);
        cyc(8'h34);
        rst = 1'b1;
        cyc(8'h00);
        rst = 1'b0;
        checks++; if (mem_addr !== 12'h000 || rd_valid !== 1'b0) begin errors++; $display("FAIL rstw_state got=%h/%b exp=000/0", mem_addr, rd_valid); end
        checks++; if ({bus_in, mem_rd, mem_wr, io_mode, io_sel} !== 12'h0) begin errors++; $display("FAIL rstw_outputs got=%h exp=0", {bus_in, mem_rd, mem_wr, io_mode, io_sel}); end
        cyc(8'h55);
        cyc(8'h00);
        cyc(8'h00);
        checks++; if (obs_mem.size() != 0 || obs_io.size() != 0) begin errors++; $display("FAIL rstw_no_write got=%0d exp=0", obs_mem.size() + obs_io.size()); end
    endtask

    initial begin
        rst      = 1'b1;
        bus_out  = 8'h00;
        io_rdata = 12'hABC;
        for (int i = 0; i < 4096; i++) mem[i] = 12'(i * 7 + 1);
        mem[12'o0512] = 12'o7342;
        mem[12'h001]  = 12'h111;
        mem[12'h002]  = 12'h2A7;
        test_reset();
        test_latch();
        test_write();
`ifdef PDP8_BUS_IO_EN
        test_io();
`else
        test_no_io();
`endif
        test_back_to_back();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
